// File: rtl/dom_sqscmul_gf2_sched.sv
// Issue scheduler for one shared DOM GF(2^2) square-scale-multiply unit:
// round-robin grant, one fresh randomness word per op, latency-tracked tagged result FIFO.
module dom_sqscmul_gf2_sched #(
   parameter  int unsigned SHARES     = 2,
   parameter  int unsigned NREQ       = 2,
   parameter  int unsigned LAT        = 1,
   parameter  int unsigned ZW         = SHARES*(SHARES-1),
   parameter  int unsigned BW         = 2,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned W          = 2*SHARES,
   localparam int unsigned IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 ClkxCI,
   input  logic                 RstxBI,
   input  logic                 ClrxSI,
   input  logic [NREQ-1:0]      ReqValidxSI,
   output logic [NREQ-1:0]      ReqReadyxSO,
   input  logic [NREQ*W-1:0]    ReqXxDI,
   input  logic [NREQ*W-1:0]    ReqYxDI,
   input  logic                 RndValidxSI,
   output logic                 RndReadyxSO,
   input  logic [ZW+BW-1:0]     RndxDI,
   output logic [W-1:0]         MulXxDO,
   output logic [W-1:0]         MulYxDO,
   output logic [ZW-1:0]        MulZxDO,
   output logic [BW-1:0]        MulBxDO,
   input  logic [W-1:0]         MulQxDI,
   output logic                 ResValidxSO,
   input  logic                 ResReadyxSI,
   output logic [W-1:0]         ResQxDO,
   output logic [IDW-1:0]       ResIdxDO
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [IDW-1:0]  rrPtrxDP, rrNextxS, grantIdxS;
   logic [NREQ-1:0] grantxS;
   logic            issuexS, creditOkxS;

   logic [W-1:0]    mulXxDP, mulYxDP;
   logic [ZW-1:0]   mulZxDP;
   logic [BW-1:0]   mulBxDP;

   logic [LAT:0]    pipeVxDP;
   logic [IDW-1:0]  pipeIdxDP [LAT+1];

   logic [CW-1:0]   inFlightxDP, fifoCntxDP;
   logic [PW-1:0]   wrPtrxDP, rdPtrxDP;
   logic [W-1:0]    qMemxDP  [FIFO_DEPTH];
   logic [IDW-1:0]  idMemxDP [FIFO_DEPTH];
   logic            fifoWrxS, fifoPopxS;

   // Credits cover both stored results and ops still inside the unit, so a write is never dropped.
   assign creditOkxS = (32'(fifoCntxDP) + 32'(inFlightxDP)) < FIFO_DEPTH;

   always_comb begin
      grantxS   = '0;
      grantIdxS = '0;
      issuexS   = 1'b0;
      if (RstxBI && RndValidxSI && creditOkxS && !ClrxSI) begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!issuexS && ReqValidxSI[i] && (IDW'(i) >= rrPtrxDP)) begin
               issuexS      = 1'b1;
               grantxS[i]   = 1'b1;
               grantIdxS    = IDW'(i);
            end
         end
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (!issuexS && ReqValidxSI[i] && (IDW'(i) < rrPtrxDP)) begin
               issuexS      = 1'b1;
               grantxS[i]   = 1'b1;
               grantIdxS    = IDW'(i);
            end
         end
      end
   end

   assign rrNextxS    = (grantIdxS == IDW'(NREQ-1)) ? '0 : grantIdxS + IDW'(1);
   assign ReqReadyxSO = grantxS;
   assign RndReadyxSO = issuexS;

   assign fifoWrxS  = pipeVxDP[LAT] & ~ClrxSI;
   assign fifoPopxS = (fifoCntxDP != '0) & ResReadyxSI;

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         rrPtrxDP    <= '0;
         mulXxDP     <= '0;
         mulYxDP     <= '0;
         mulZxDP     <= '0;
         mulBxDP     <= '0;
         pipeVxDP    <= '0;
         for (int unsigned j = 0; j <= LAT; j++) pipeIdxDP[j] <= '0;
         inFlightxDP <= '0;
         fifoCntxDP  <= '0;
         wrPtrxDP    <= '0;
         rdPtrxDP    <= '0;
      end else begin
         if (issuexS) rrPtrxDP <= rrNextxS;

         // Idle cycles load zeros so randomness is never reused and ops never overlap at the unit.
         if (issuexS) begin
            mulXxDP <= ReqXxDI[grantIdxS*W +: W];
            mulYxDP <= ReqYxDI[grantIdxS*W +: W];
            mulZxDP <= RndxDI[ZW-1:0];
            mulBxDP <= RndxDI[ZW+BW-1:ZW];
         end else begin
            mulXxDP <= '0;
            mulYxDP <= '0;
            mulZxDP <= '0;
            mulBxDP <= '0;
         end
         pipeVxDP[0]  <= issuexS;
         pipeIdxDP[0] <= grantIdxS;
         for (int unsigned j = 1; j <= LAT; j++) begin
            pipeVxDP[j]  <= pipeVxDP[j-1] & ~ClrxSI;
            pipeIdxDP[j] <= pipeIdxDP[j-1];
         end

         if (ClrxSI) begin
            inFlightxDP <= '0;
            fifoCntxDP  <= '0;
            wrPtrxDP    <= '0;
            rdPtrxDP    <= '0;
         end else begin
            unique case ({issuexS, fifoWrxS})
               2'b10:   inFlightxDP <= inFlightxDP + CW'(1);
               2'b01:   inFlightxDP <= inFlightxDP - CW'(1);
               default: ;
            endcase
            unique case ({fifoWrxS, fifoPopxS})
               2'b10:   fifoCntxDP <= fifoCntxDP + CW'(1);
               2'b01:   fifoCntxDP <= fifoCntxDP - CW'(1);
               default: ;
            endcase
            if (fifoWrxS)  wrPtrxDP <= wrPtrxDP + PW'(1);
            if (fifoPopxS) rdPtrxDP <= rdPtrxDP + PW'(1);
         end
      end
   end

   always_ff @(posedge ClkxCI) begin
      if (fifoWrxS) begin
         qMemxDP[wrPtrxDP]  <= MulQxDI;
         idMemxDP[wrPtrxDP] <= pipeIdxDP[LAT];
      end
   end

   assign MulXxDO     = mulXxDP;
   assign MulYxDO     = mulYxDP;
   assign MulZxDO     = mulZxDP;
   assign MulBxDO     = mulBxDP;
   assign ResValidxSO = (fifoCntxDP != '0);
   assign ResQxDO     = ResValidxSO ? qMemxDP[rdPtrxDP]  : '0;
   assign ResIdxDO    = ResValidxSO ? idMemxDP[rdPtrxDP] : '0;

endmodule
